sram_c_arbiter: RTL



---
 rtl/npu_mem_pkg.sv | 18 +
 rtl/sram_c_arbiter_rr_arb2.sv | 70 +++++++
 rtl/sram_c_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/npu_mem_pkg.sv
// Shared types and sizes for the NPU memory subsystem (sram_C access path).
package npu_mem_pkg;

  localparam int unsigned SRAM_C_ADDR_W = 10;
  localparam int unsigned SRAM_C_DATA_W = 8;

  typedef logic req_id_t;

  localparam req_id_t REQ_PE   = 1'b0;
  localparam req_id_t REQ_HOST = 1'b1;

  // Read-return tag carried down the response pipeline
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rsp_tag_t;

endpackage

// File: rtl/sram_c_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a bounded burst: one requester keeps the grant
// for at most MAX_BURST consecutive accepts while the other one is waiting.
module rr_arb2
  import npu_mem_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant_c
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

  req_id_t           prio, prio_n;
  req_id_t           last_id, last_n;
  logic [CNT_W-1:0]  burst_cnt, cnt_n, cnt_inc;
  req_id_t           gnt_id;
  logic              gnt_any;

  // A lone requester always wins; on a tie the priority holder wins
  always_comb begin
    grant_c = 2'b00;
    case (req)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = (prio == REQ_HOST) ? 2'b10 : 2'b01;
      default: grant_c = 2'b00;
    endcase
  end

  assign gnt_id  = req_id_t'(grant_c[1]);
  assign gnt_any = |grant_c;

  always_comb begin
    prio_n  = prio;
    last_n  = last_id;
    cnt_n   = burst_cnt;
    cnt_inc = burst_cnt;
    if (gnt_any) begin
      if ((gnt_id == last_id) && (burst_cnt != '0))
        cnt_inc = (burst_cnt >= MAX_C) ? MAX_C : burst_cnt + CNT_W'(1);
      else
        cnt_inc = CNT_W'(1);
      last_n = gnt_id;
      // Burst exhausted with the other side waiting: hand priority over
      if ((cnt_inc >= MAX_C) && req[~gnt_id]) begin
        prio_n = ~gnt_id;
        cnt_n  = '0;
      end else begin
        cnt_n = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= REQ_PE;
      last_id   <= REQ_PE;
      burst_cnt <= '0;
    end else begin
      prio      <= prio_n;
      last_id   <= last_n;
      burst_cnt <= cnt_n;
    end
  end

endmodule

// File: rtl/sram_c_arbiter.sv
// Shares single-port sram_C between PE writeback (port 0) and host readout (port 1);
// one registered access per cycle, read data routed back by requester tag.
module sram_c_arbiter
  import npu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = SRAM_C_ADDR_W,
  parameter int unsigned DATA_W    = SRAM_C_DATA_W,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                rpll_clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                sram_C_we,
  output logic [ADDR_W-1:0]   sram_C_addr,
  output logic [DATA_W-1:0]   sram_C_din,
  input  logic [DATA_W-1:0]   sram_C_dout,
  output logic                busy
);

  localparam int unsigned PIPE_D = READ_LAT + 1;

  logic [1:0]        grant;
  logic [1:0]        acc;
  logic              acc_any;
  req_id_t           acc_id;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  rsp_tag_t          pipe [PIPE_D];
  rsp_tag_t          tag_out;

  rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk     (rpll_clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .grant_c (grant)
  );

  assign req_ready = grant;
  assign acc       = req_valid & grant;
  assign acc_any   = |acc;
  assign acc_id    = req_id_t'(acc[1]);
  assign acc_addr  = acc_id ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
  assign acc_wdata = acc_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  // SRAM drive: we pulses per accepted write, addr/din hold when idle
  always_ff @(posedge rpll_clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_C_we   <= 1'b0;
      sram_C_addr <= '0;
      sram_C_din  <= '0;
    end else begin
      sram_C_we <= acc_any & req_we[acc_id];
      if (acc_any) begin
        sram_C_addr <= acc_addr;
        sram_C_din  <= acc_wdata;
      end
    end
  end

  // Issue register plus READ_LAT stages; the last stage lines up with sram_C_dout
  always_ff @(posedge rpll_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_D; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: acc_any & ~req_we[acc_id], id: acc_id};
      for (int i = 1; i < PIPE_D; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out   = pipe[PIPE_D-1];
  assign rsp_valid = !tag_out.valid        ? 2'b00 :
                     (tag_out.id == REQ_HOST) ? 2'b10 : 2'b01;
  assign rsp_rdata = tag_out.valid ? sram_C_dout : '0;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < PIPE_D; i++) busy = busy | pipe[i].valid;
  end

endmodule
